regfile_dump_ctrl: RTL and testbench

Debug-side controller for the register file's read port 1. In normal operation it passes the decode stage's read address straight through to the register file. On a debug request, while the pipeline is halted, it takes over the port and reads all 32 registers in order. Each 32-bit word is serialized into bytes on a valid/ready stream for the debug UART transmitter.

---
 rtl/regfile_dump_ctrl.sv | 92 +++++++++
 tb/tb_regfile_dump_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// Debug dump controller for register file read port 1: passes the decode address
// through when idle, otherwise walks all registers and streams each word LSB-first.
module regfile_dump_ctrl #(
  parameter int N_REGS = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_halted,
  input  logic [ADDR_W-1:0] i_id_read_register,
  output logic [ADDR_W-1:0] o_rf_read_register,
  input  logic [DATA_W-1:0] i_rf_read_data,
  output logic [7:0]        o_byte,
  output logic              o_byte_valid,
  input  logic              i_byte_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(NBYTES - 1);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(N_REGS - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [BCNT_W-1:0] bcnt;
  logic [DATA_W-1:0] sh;
  logic              hs;

  // Outputs decode straight from registered state, so valid never sees ready.
  assign o_byte_valid = (state == S_SEND);
  assign o_byte       = sh[7:0];
  assign o_busy       = (state != S_IDLE);
  assign o_done       = (state == S_DONE);
  assign hs           = o_byte_valid & i_byte_ready;

  // Zero-latency pass-through while idle; the dump owns the port otherwise.
  always_comb begin
    o_rf_read_register = i_id_read_register;
    if (state != S_IDLE) o_rf_read_register = idx;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
      idx   <= '0;
      bcnt  <= '0;
      sh    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start && i_halted) begin
            idx   <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_CAPTURE;
        S_CAPTURE: begin
          sh    <= i_rf_read_data;
          bcnt  <= '0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (hs) begin
            sh   <= sh >> 8;
            bcnt <= bcnt + 1'b1;
            if (bcnt == LAST_BYTE) begin
              if (idx == LAST_REG) begin
                state <= S_DONE;
              end else begin
                idx   <= idx + 1'b1;
                state <= S_ISSUE;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: register file model with 1-cycle read latency and a
// byte scoreboard filled at dump start, drained by a stream monitor.
module tb_regfile_dump_ctrl;

  localparam int N_REGS = 32;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              i_rst;
  logic              i_start;
  logic              i_halted;
  logic [ADDR_W-1:0] i_id_read_register;
  logic [ADDR_W-1:0] o_rf_read_register;
  logic [DATA_W-1:0] i_rf_read_data;
  logic [7:0]        o_byte;
  logic              o_byte_valid;
  logic              i_byte_ready;
  logic              o_busy;
  logic              o_done;

  regfile_dump_ctrl #(.N_REGS(N_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .i_clk              (clk),
    .i_rst              (i_rst),
    .i_start            (i_start),
    .i_halted           (i_halted),
    .i_id_read_register (i_id_read_register),
    .o_rf_read_register (o_rf_read_register),
    .i_rf_read_data     (i_rf_read_data),
    .o_byte             (o_byte),
    .o_byte_valid       (o_byte_valid),
    .i_byte_ready       (i_byte_ready),
    .o_busy             (o_busy),
    .o_done             (o_done)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] regs [N_REGS];
  always @(posedge clk) i_rf_read_data <= regs[o_rf_read_register];

  int        nvec = 0;
  int        miss = 0;
  int        cyc = 0;
  int        rdy_mode = 0;
  int        pulse_cyc = -1;
  int        stalls = 0;
  int        done_cnt = 0;
  logic [7:0] sb [$];
  logic [7:0] held;
  logic       hold_chk = 1'b0;

  // Stream monitor: handshakes are judged mid-cycle, ahead of the edge that takes them.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (i_rst) begin
      hold_chk = 1'b0;
    end else begin
      if (o_done) done_cnt++;
      if (hold_chk) begin
        nvec++;
        if (!o_byte_valid || o_byte !== held) begin
          miss++;
          $display("FAIL hold_stable: valid=%0b byte=%02h, required valid=1 byte=%02h",
                   o_byte_valid, o_byte, held);
        end
      end
      hold_chk = o_byte_valid && !i_byte_ready;
      held     = o_byte;
      if (o_byte_valid && !i_byte_ready) stalls++;
      if (o_byte_valid && i_byte_ready) begin
        nvec++;
        if (sb.size() == 0) begin
          miss++;
          $display("FAIL stream_extra: got byte %02h, required none", o_byte);
        end else begin
          exp_b = sb.pop_front();
          if (o_byte !== exp_b) begin
            miss++;
            $display("FAIL stream_byte: got %02h, required %02h (cycle %0d)", o_byte, exp_b, cyc);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    i_byte_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    if (pulse_cyc > 0) i_start = (cyc == pulse_cyc);
  endtask

  task automatic push_expected();
    for (int r = 0; r < N_REGS; r++)
      for (int b = 0; b < DATA_W / 8; b++)
        sb.push_back(8'((regs[r] >> (8 * b)) & 32'hFF));
  endtask

  // Launches a dump accepted at edge 0 and waits for o_done; reports its cycle.
  task automatic run_dump(input int mode, input int pulse, output int done_cyc);
    rdy_mode  = mode;
    pulse_cyc = pulse;
    stalls    = 0;
    done_cnt  = 0;
    push_expected();
    i_start  = 1'b1;
    i_halted = 1'b1;
    i_byte_ready = 1'b1;
    cyc = 0;
    tick();
    i_start  = 1'b0;
    i_halted = 1'b0;
    while (!o_done && cyc < 3000) tick();
    done_cyc = cyc;
    nvec++;
    if (!o_done) begin
      miss++;
      $display("FAIL dump_timeout: o_done not seen by cycle %0d, required pulse", cyc);
    end
    pulse_cyc = -1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    i_start = 1'b0;
    i_halted = 1'b0;
    i_byte_ready = 1'b1;
    i_id_read_register = 5'd7;
    tick();
    tick();
    nvec++;
    if (o_rf_read_register !== 5'd7 || o_busy !== 1'b0 || o_byte_valid !== 1'b0 ||
        o_done !== 1'b0 || o_byte !== 8'h00) begin
      miss++;
      $display("FAIL reset_state: addr=%0d busy=%0b valid=%0b done=%0b byte=%02h, required 7 0 0 0 00",
               o_rf_read_register, o_busy, o_byte_valid, o_done, o_byte);
    end
    i_rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    for (int a = 0; a < N_REGS; a++) begin
      i_id_read_register = ADDR_W'(a);
      #1;
      nvec++;
      if (o_rf_read_register !== ADDR_W'(a) || o_busy !== 1'b0 || o_byte_valid !== 1'b0) begin
        miss++;
        $display("FAIL passthrough: addr=%0d busy=%0b valid=%0b, required %0d 0 0",
                 o_rf_read_register, o_busy, o_byte_valid, a);
      end
      tick();
    end
  endtask

  task automatic test_start_gating();
    i_id_read_register = 5'd9;
    i_start  = 1'b1;
    i_halted = 1'b0;
    tick();
    tick();
    nvec++;
    if (o_busy !== 1'b0 || o_byte_valid !== 1'b0 || o_rf_read_register !== 5'd9) begin
      miss++;
      $display("FAIL start_unhalted: busy=%0b valid=%0b addr=%0d, required 0 0 9",
               o_busy, o_byte_valid, o_rf_read_register);
    end
    i_halted = 1'b1;
    tick();
    i_start  = 1'b0;
    i_halted = 1'b0;
    nvec++;
    if (o_busy !== 1'b1 || o_rf_read_register !== 5'd0) begin
      miss++;
      $display("FAIL start_halted: busy=%0b addr=%0d, required 1 0", o_busy, o_rf_read_register);
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tick();
  endtask

  task automatic check_dump_end(input string name, input int done_cyc, input int want_cyc);
    nvec++;
    if (done_cyc !== want_cyc) begin
      miss++;
      $display("FAIL %s_done_cycle: got %0d, required %0d", name, done_cyc, want_cyc);
    end
    tick();
    nvec++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || done_cnt !== 1) begin
      miss++;
      $display("FAIL %s_end: done=%0b busy=%0b pulses=%0d, required 0 0 1",
               name, o_done, o_busy, done_cnt);
    end
    nvec++;
    if (sb.size() != 0) begin
      miss++;
      $display("FAIL %s_bytes_left: %0d unsent, required 0", name, sb.size());
    end
    sb.delete();
  endtask

  task automatic test_full_dump();
    int dc;
    run_dump(0, -1, dc);
    check_dump_end("full", dc, 193);
  endtask

  task automatic test_backpressure();
    int dc;
    regs[5] = 32'hDEADBEEF;
    run_dump(1, -1, dc);
    check_dump_end("bp", dc, 193 + stalls);
    nvec++;
    if (stalls == 0) begin
      miss++;
      $display("FAIL bp_stalls: got 0 stall cycles, required >0");
    end
    regs[5] = 32'h1000_0005;
  endtask

  task automatic test_reset_mid_dump();
    int dc;
    push_expected();
    rdy_mode = 0;
    done_cnt = 0;
    i_start  = 1'b1;
    i_halted = 1'b1;
    cyc = 0;
    tick();
    i_start  = 1'b0;
    i_halted = 1'b0;
    while (cyc < 65) tick();
    nvec++;
    if (o_byte_valid !== 1'b1 || o_byte !== 8'h00 || o_rf_read_register !== 5'd10) begin
      miss++;
      $display("FAIL mid_send: valid=%0b byte=%02h addr=%0d, required 1 00 10",
               o_byte_valid, o_byte, o_rf_read_register);
    end
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    sb.delete();
    nvec++;
    if (o_byte_valid !== 1'b0 || o_busy !== 1'b0) begin
      miss++;
      $display("FAIL mid_reset: valid=%0b busy=%0b, required 0 0", o_byte_valid, o_busy);
    end
    for (int i = 0; i < 10; i++) tick();
    nvec++;
    if (done_cnt !== 0 || o_busy !== 1'b0) begin
      miss++;
      $display("FAIL mid_no_done: pulses=%0d busy=%0b, required 0 0", done_cnt, o_busy);
    end
    run_dump(0, -1, dc);
    check_dump_end("restart", dc, 193);
  endtask

  task automatic test_start_while_busy();
    int dc;
    run_dump(0, 50, dc);
    check_dump_end("busy_start", dc, 193);
    for (int i = 0; i < 5; i++) tick();
    nvec++;
    if (o_busy !== 1'b0) begin
      miss++;
      $display("FAIL busy_start_relaunch: busy=%0b, required 0", o_busy);
    end
  endtask

  initial begin
    for (int k = 0; k < N_REGS; k++) regs[k] = 32'h1000_0000 + k;
    test_reset();
    test_passthrough();
    test_start_gating();
    test_full_dump();
    test_backpressure();
    test_reset_mid_dump();
    test_start_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, miss);
    $finish;
  end

endmodule
